// File: rtl/sync_fifo_param.sv
// Single-clock FIFO over a circular RAM buffer with occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_param #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg, overflow_reg, underflow_reg;
  logic             rd_acc, wr_acc;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = rd_en & (count_reg != '0);
  assign wr_acc = wr_en & ((count_reg != FULL_CNT) | rd_acc);

  // RAM storage is never reset; stale words are unreachable through the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_acc;
      if (rd_acc) begin
        rd_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
      end
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // A new error in the same cycle wins over the clear request.
      if (wr_en && !wr_acc)  overflow_reg <= 1'b1;
      else if (clr_err)      overflow_reg <= 1'b0;
      if (rd_en && !rd_acc)  underflow_reg <= 1'b1;
      else if (clr_err)      underflow_reg <= 1'b0;
    end
  end

  assign rd_data      = rd_data_reg;
  assign rd_valid     = rd_valid_reg;
  assign count        = count_reg;
  assign full         = (count_reg == FULL_CNT);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed scenarios then random traffic, all
// checked every cycle against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en, rd_en, clr_err;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, full, empty, almost_full, almost_empty;
  logic [2:0]       count;
  logic             overflow, underflow;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain queue of stored words plus expected registered outputs.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_data;
  logic             exp_valid, exp_ovf, exp_udf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    int sz;
    sz = q.size();
    check({tag, ".rd_data"},      32'(rd_data),      32'(exp_data));
    check({tag, ".rd_valid"},     32'(rd_valid),     32'(exp_valid));
    check({tag, ".count"},        32'(count),        32'(sz));
    check({tag, ".full"},         32'(full),         32'(sz == DEPTH));
    check({tag, ".empty"},        32'(empty),        32'(sz == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
    check({tag, ".overflow"},     32'(overflow),     32'(exp_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(exp_udf));
  endtask

  // One clock cycle: drive, clock, advance model, compare; one line per transaction.
  task automatic cyc(input string tag, input logic w, input logic [WIDTH-1:0] d,
                     input logic r, input logic c);
    logic rd_ok, wr_ok;
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    @(posedge clk);
    #1;
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    exp_valid = rd_ok;
    if (rd_ok) exp_data = q.pop_front();
    if (wr_ok) q.push_back(d);
    if (w && !wr_ok) exp_ovf = 1'b1;
    else if (c)      exp_ovf = 1'b0;
    if (r && !rd_ok) exp_udf = 1'b1;
    else if (c)      exp_udf = 1'b0;
    $display("%s: wr=%0b d=%0h rd=%0b clr=%0b -> rd_data=%0h v=%0b count=%0d ovf=%0b udf=%0b",
             tag, w, d, r, c, rd_data, rd_valid, count, overflow, underflow);
    compare_all(tag);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    model_reset();
    #12;
    compare_all("reset");
    rst = 1'b1;

    // Async reset mid-traffic with two words stored.
    cyc("t1_wr", 1'b1, 4'h3, 1'b0, 1'b0);
    cyc("t1_wr", 1'b1, 4'h8, 1'b0, 1'b0);
    cyc("t1_rd", 1'b0, 4'h0, 1'b1, 1'b0);
    cyc("t1_wr", 1'b1, 4'h6, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all("t1_async_rst");
    #1 rst = 1'b1;

    // Fill and drain order.
    cyc("t2_wr", 1'b1, 4'b0101, 1'b0, 1'b0);
    cyc("t2_wr", 1'b1, 4'b0100, 1'b0, 1'b0);
    cyc("t2_wr", 1'b1, 4'b0111, 1'b0, 1'b0);
    cyc("t2_wr", 1'b1, 4'b1101, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("t2_rd", 1'b0, 4'h0, 1'b1, 1'b0);
    cyc("t2_idle", 1'b0, 4'h0, 1'b0, 1'b0);

    // Overflow on full, then clear.
    for (int i = 0; i < 4; i++) cyc("t3_fill", 1'b1, 4'(i + 2), 1'b0, 1'b0);
    cyc("t3_ovf", 1'b1, 4'b1111, 1'b0, 1'b0);
    cyc("t3_clr", 1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc("t3_drain", 1'b0, 4'h0, 1'b1, 1'b0);

    // Full with simultaneous read and write.
    cyc("t4_fill", 1'b1, 4'hA, 1'b0, 1'b0);
    cyc("t4_fill", 1'b1, 4'hB, 1'b0, 1'b0);
    cyc("t4_fill", 1'b1, 4'hC, 1'b0, 1'b0);
    cyc("t4_fill", 1'b1, 4'hD, 1'b0, 1'b0);
    cyc("t4_rdwr", 1'b1, 4'b1001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("t4_drain", 1'b0, 4'h0, 1'b1, 1'b0);

    // Read+write on empty: no bypass, underflow set.
    cyc("t5_rdwr", 1'b1, 4'b0001, 1'b1, 1'b0);
    cyc("t5_rd", 1'b0, 4'h0, 1'b1, 1'b0);
    cyc("t5_clr", 1'b0, 4'h0, 1'b0, 1'b1);

    // Wrap-around with alternating single write/read.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cyc("t6_wr", 1'b1, 4'(i * 3 + 1), 1'b0, 1'b0);
      else            cyc("t6_rd", 1'b0, 4'h0, 1'b1, 1'b0);
    end

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cyc("rand", 1'($urandom_range(0, 99) < 55), 4'($urandom),
          1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 8));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
